// File: rtl/ifetch_prefetch.sv
// rtl/ifetch_prefetch.sv - instruction fetch front end with prefetch FIFO and redirect/trap handling
module ifetch_prefetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_start_addr,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_rd_en,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  input  logic        i_id_ready,
  output logic        o_misaligned
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          kill;
  logic          misaligned;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] occ;
  logic          pop, push, redirect_run, start_ok, target_aligned;

  assign redirect_run   = (state == RUN) & i_redirect;
  assign start_ok       = i_start & (state != RUN);
  assign target_aligned = (i_redirect_addr[1:0] == 2'b00);

  assign o_id_valid = (count != '0);
  assign pop        = o_id_valid & i_id_ready;
  // A redirect flushes the FIFO at the same edge, so the response is dropped.
  assign push       = inflight & ~kill & ~redirect_run;

  // Occupancy once this cycle's pop and the pending response settle.
  assign occ = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);

  assign o_imem_rd_en = (state == RUN) & ~i_redirect & (occ < (AW+2)'(DEPTH));
  assign o_imem_addr  = pc;
  assign o_misaligned = misaligned;
  assign o_id_pc      = o_id_valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign o_id_instr   = o_id_valid ? fifo_instr[rd_ptr] : 32'h0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, TRAP: if (i_start) state_nxt = RUN;
      RUN:        if (i_redirect && !target_aligned) state_nxt = TRAP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      kill        <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      inflight <= o_imem_rd_en;
      kill     <= redirect_run & inflight;
      if (o_imem_rd_en) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (start_ok) begin
        pc         <= i_start_addr;
        misaligned <= 1'b0;
      end else if (redirect_run) begin
        if (target_aligned) pc <= i_redirect_addr;
        else                misaligned <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_run) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb/tb_ifetch_prefetch.sv - directed self-checking bench for ifetch_prefetch
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready = 1'b0;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  ifetch_prefetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (start),
    .i_start_addr    (start_addr),
    .i_redirect      (redirect),
    .i_redirect_addr (redirect_addr),
    .o_imem_addr     (imem_addr),
    .o_imem_rd_en    (imem_rd_en),
    .i_imem_rdata    (imem_rdata),
    .o_id_valid      (id_valid),
    .o_id_pc         (id_pc),
    .o_id_instr      (id_instr),
    .i_id_ready      (id_ready),
    .o_misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  // Synchronous instruction RAM, one-cycle read latency
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic en, input logic [31:0] addr);
    chk({tag, ".rd_en"}, 32'(imem_rd_en), 32'(en));
    if (en) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(id_valid), 32'(v));
    chk({tag, ".pc"}, id_pc, v ? pc : 32'h0);
    chk({tag, ".instr"}, id_instr, v ? mem_word(pc) : 32'h0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst.rd_en", 32'(imem_rd_en), 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.mis", 32'(misaligned), 32'h0);
    chk_id("rst", 1'b0, 32'h0);

    tick(); rst_n = 1'b1; settle();
    chk_fetch("idle", 1'b0, 32'h0);

    // Start at 0x100 with decode always ready
    tick(); start = 1'b1; start_addr = 32'h100; id_ready = 1'b1; settle();
    chk_fetch("s.c0", 1'b0, 32'h0);
    tick(); start = 1'b0; settle();
    chk_fetch("s.c1", 1'b1, 32'h100); chk_id("s.c1", 1'b0, 32'h0);
    tick(); settle();
    chk_fetch("s.c2", 1'b1, 32'h104); chk_id("s.c2", 1'b0, 32'h0);
    tick(); settle(); chk_id("s.c3", 1'b1, 32'h100);
    tick(); settle(); chk_id("s.c4", 1'b1, 32'h104);
    tick(); settle(); chk_id("s.c5", 1'b1, 32'h108);

    // Decode stall for six cycles, then release
    tick(); pulse_reset(); start = 1'b1; start_addr = 32'h100; id_ready = 1'b0; settle();
    tick(); start = 1'b0; settle(); chk_fetch("st.c1", 1'b1, 32'h100);
    tick(); settle(); chk_fetch("st.c2", 1'b1, 32'h104);
    tick(); settle(); chk_fetch("st.c3", 1'b0, 32'h0); chk_id("st.c3", 1'b1, 32'h100);
    tick(); settle(); chk_fetch("st.c4", 1'b0, 32'h0);
    tick(); settle(); chk_fetch("st.c5", 1'b0, 32'h0);
    tick(); settle(); chk_fetch("st.c6", 1'b0, 32'h0); chk_id("st.c6", 1'b1, 32'h100);
    tick(); id_ready = 1'b1; settle();
    chk_id("st.c7", 1'b1, 32'h100); chk_fetch("st.c7", 1'b1, 32'h108);
    tick(); settle(); chk_id("st.c8", 1'b1, 32'h104); chk_fetch("st.c8", 1'b1, 32'h10c);
    tick(); settle(); chk_id("st.c9", 1'b1, 32'h108);
    tick(); settle(); chk_id("st.c10", 1'b1, 32'h10c);

    // Redirect to 0x200 with 0x104 at the head and 0x108 in flight
    tick(); pulse_reset(); start = 1'b1; start_addr = 32'h100; id_ready = 1'b0; settle();
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    id_ready = 1'b1; settle();
    chk_id("rd.c7", 1'b1, 32'h100);
    tick(); redirect = 1'b1; redirect_addr = 32'h200; settle();
    chk_id("rd.c8", 1'b1, 32'h104); chk_fetch("rd.c8", 1'b0, 32'h0);
    tick(); redirect = 1'b0; settle();
    chk_id("rd.c9", 1'b0, 32'h0); chk_fetch("rd.c9", 1'b1, 32'h200);
    tick(); settle(); chk_id("rd.c10", 1'b0, 32'h0); chk_fetch("rd.c10", 1'b1, 32'h204);
    tick(); settle(); chk_id("rd.c11", 1'b1, 32'h200);

    // Misaligned redirect traps; redirect ignored in TRAP; restart clears the flag
    tick(); redirect = 1'b1; redirect_addr = 32'h202; settle();
    chk_id("mis.c12", 1'b1, 32'h204); chk_fetch("mis.c12", 1'b0, 32'h0);
    tick(); redirect = 1'b1; redirect_addr = 32'h600; settle();
    chk("mis.c13.flag", 32'(misaligned), 32'h1);
    chk_id("mis.c13", 1'b0, 32'h0); chk_fetch("mis.c13", 1'b0, 32'h0);
    tick(); redirect = 1'b0; start = 1'b1; start_addr = 32'h300; settle();
    chk("mis.c14.flag", 32'(misaligned), 32'h1);
    chk_id("mis.c14", 1'b0, 32'h0); chk_fetch("mis.c14", 1'b0, 32'h0);
    tick(); start = 1'b0; settle();
    chk("mis.c15.flag", 32'(misaligned), 32'h0); chk_fetch("mis.c15", 1'b1, 32'h300);
    tick(); settle();
    tick(); redirect = 1'b1; redirect_addr = 32'h400; settle();
    chk_id("mis.c17", 1'b1, 32'h300); chk_fetch("mis.c17", 1'b0, 32'h0);

    // Back-to-back redirects: 0x500 wins
    tick(); redirect = 1'b1; redirect_addr = 32'h500; settle();
    chk_id("bb.c18", 1'b0, 32'h0); chk_fetch("bb.c18", 1'b0, 32'h0);
    tick(); redirect = 1'b0; settle();
    chk_id("bb.c19", 1'b0, 32'h0); chk_fetch("bb.c19", 1'b1, 32'h500);
    tick(); settle(); chk_id("bb.c20", 1'b0, 32'h0);
    tick(); id_ready = 1'b0; settle();
    chk_id("bb.c21", 1'b1, 32'h500); chk_fetch("bb.c21", 1'b0, 32'h0);
    tick(); settle(); chk_id("bb.c22", 1'b1, 32'h500);

    // Asynchronous reset with the FIFO full
    #1; rst_n = 1'b0; #1;
    chk("ar.rd_en", 32'(imem_rd_en), 32'h0);
    chk("ar.addr", imem_addr, 32'h0);
    chk("ar.mis", 32'(misaligned), 32'h0);
    chk_id("ar", 1'b0, 32'h0);
    rst_n = 1'b1; id_ready = 1'b1;
    tick(); settle(); chk_fetch("ar.c1", 1'b0, 32'h0);
    tick(); settle(); chk_fetch("ar.c2", 1'b0, 32'h0); chk_id("ar.c2", 1'b0, 32'h0);
    tick(); settle(); chk_id("ar.c3", 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
